oam_dma_ctrl: RTL

Sprite-attribute DMA engine that sits directly upstream of the 64 KiB system RAM on the CPU bus. A CPU write to the DMA page register starts the engine. It halts the CPU, takes over the RAM address/control lines, and copies `XFER_LEN` consecutive bytes from page `{page, 8'h00}` into PPU OAM. It then returns the bus to the CPU. The top level muxes RAM `addr`/`cs_n`/`rw_n` between CPU and this block using `bus_grant`.

---
 rtl/oam_dma_if.sv | 31 +++
 rtl/oam_dma_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/oam_dma_if.sv
// Bundle of the CPU register strobe, RAM bus and OAM write port used by the
// sprite-attribute DMA engine. master = DMA engine, slave = surrounding system.
interface oam_dma_if;
    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic        cpu_rdy;
    logic        bus_grant;
    logic        dma_busy;
    logic        done;
    logic [15:0] bus_addr;
    logic        bus_cs_n;
    logic        bus_rw_n;
    logic [7:0]  bus_data_in;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;

    modport master (
        input  reg_we, reg_wdata, bus_data_in,
        output cpu_rdy, bus_grant, dma_busy, done,
               bus_addr, bus_cs_n, bus_rw_n,
               oam_addr, oam_wdata, oam_we
    );

    modport slave (
        output reg_we, reg_wdata, bus_data_in,
        input  cpu_rdy, bus_grant, dma_busy, done,
               bus_addr, bus_cs_n, bus_rw_n,
               oam_addr, oam_wdata, oam_we
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-attribute DMA: halts the CPU, copies XFER_LEN bytes from page {page,8'h00}
// of system RAM into PPU OAM, then hands the bus back.
module oam_dma_ctrl #(
    parameter int XFER_LEN  = 256,
    parameter bit ALIGN_ODD = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    oam_dma_if.master  dma
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] page_r;
    logic [7:0] page_nxt_s;
    logic [7:0] idx_r;
    logic [7:0] idx_nxt_s;
    logic       par_r;
    logic       cpu_rdy_r;
    logic       bus_cs_n_r;
    logic       oam_we_r;
    logic       done_r;

    // Next-state decode; reg_we is only honoured in IDLE so a transfer can never restart.
    always_comb begin
        state_nxt_s = state_r;
        page_nxt_s  = page_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (dma.reg_we) begin
                    page_nxt_s  = dma.reg_wdata;
                    idx_nxt_s   = 8'd0;
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (ALIGN_ODD && par_r) begin
                    state_nxt_s = ST_ALIGN;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_ALIGN: state_nxt_s = ST_READ;
            ST_READ:  state_nxt_s = ST_WRITE;
            ST_WRITE: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    idx_nxt_s   = idx_r + 8'd1;
                    state_nxt_s = ST_READ;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, address counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            page_r     <= 8'd0;
            idx_r      <= 8'd0;
            par_r      <= 1'b0;
            cpu_rdy_r  <= 1'b1;
            bus_cs_n_r <= 1'b1;
            oam_we_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            page_r     <= page_nxt_s;
            idx_r      <= idx_nxt_s;
            par_r      <= ~par_r;
            cpu_rdy_r  <= (state_nxt_s == ST_IDLE);
            // RAM select is held through WRITE so the read data stays on the bus.
            bus_cs_n_r <= !((state_nxt_s == ST_READ) || (state_nxt_s == ST_WRITE));
            oam_we_r   <= (state_nxt_s == ST_WRITE);
            done_r     <= (state_r == ST_WRITE) && (state_nxt_s == ST_IDLE);
        end
    end

    assign dma.cpu_rdy   = cpu_rdy_r;
    assign dma.bus_grant = ~cpu_rdy_r;
    assign dma.dma_busy  = ~cpu_rdy_r;
    assign dma.done      = done_r;
    assign dma.bus_addr  = {page_r, idx_r};
    assign dma.bus_cs_n  = bus_cs_n_r;
    assign dma.bus_rw_n  = 1'b1;
    assign dma.oam_addr  = idx_r;
    assign dma.oam_wdata = dma.bus_data_in;
    assign dma.oam_we    = oam_we_r;

endmodule
